// File: rtl/dmem_pkg.sv
// Shared types and widths for the wait-state data memory stage.
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int OFF_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// Memory-stage request/response bundle between the pipeline (master) and the data memory (slave).
interface dmem_wait_ctrl_if;
  import dmem_pkg::*;
  logic              MemReadM;
  logic              MemWriteM;
  logic [WORD_W-1:0] AddrM;
  logic [WORD_W-1:0] WriteDataM;
  logic [WORD_W-1:0] ReadDataM;
  logic              MemStallM;
  logic              MisalignM;
  logic              BusyM;

  modport master (
    output MemReadM, MemWriteM, AddrM, WriteDataM,
    input  ReadDataM, MemStallM, MisalignM, BusyM
  );

  modport slave (
    input  MemReadM, MemWriteM, AddrM, WriteDataM,
    output ReadDataM, MemStallM, MisalignM, BusyM
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read; contents survive reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data-memory stage with programmable wait states; stalls the pipeline while an access is outstanding.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_wait_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES >= 2) ? CNT_W'(WAIT_CYCLES - 2) : '0;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  logic              req, aligned, complete, stall, we;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] rdata;
  logic              unused_addr;

  assign req         = bus.MemReadM | bus.MemWriteM;
  assign aligned     = (bus.AddrM[OFF_W-1:0] == '0);
  assign idx         = bus.AddrM[AW+OFF_W-1:OFF_W];
  assign unused_addr = ^bus.AddrM[WORD_W-1:AW+OFF_W];

  // Outputs are gated by reset so a held request cannot leak through while reset is asserted.
  always_comb begin
    complete = 1'b0;
    if (!reset && req && aligned)
      complete = (state_q == DONE) || (state_q == IDLE && WAIT_CYCLES == 0);
  end

  always_comb begin
    stall = 1'b0;
    if (!reset && req)
      stall = (state_q == IDLE && aligned && WAIT_CYCLES != 0) || (state_q == WAIT);
  end

  assign we            = complete & bus.MemWriteM;
  assign bus.MemStallM = stall;
  assign bus.MisalignM = !reset && req && !aligned;
  assign bus.ReadDataM = (complete && bus.MemReadM) ? rdata : '0;
  assign bus.BusyM     = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && aligned && WAIT_CYCLES != 0) begin
            busy_q <= 1'b1;
            if (WAIT_CYCLES >= 2) begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q <= DONE;
            end
          end
        end
        WAIT: begin
          // A dropped request is a pipeline flush: abandon without writing.
          if (!req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (we),
    .idx_i   (idx),
    .wdata_i (bus.WriteDataM),
    .rdata_o (rdata)
  );
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: directed vectors plus randomized traffic against a cycle-count reference model.
module tb_dmem_wait_ctrl;
  logic        clk, reset;
  logic [1:0]  rd, wr;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  st, mi, bz;
  logic [31:0] rdv [2];

  int n_chk  = 0;
  int n_fail = 0;

  // index 0: WAIT_CYCLES=2, index 1: WAIT_CYCLES=0
  dmem_wait_ctrl_if if2 ();
  dmem_wait_ctrl_if if0 ();

  dmem_wait_ctrl #(.DEPTH(256), .WAIT_CYCLES(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave));
  dmem_wait_ctrl #(.DEPTH(256), .WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));

  assign if2.MemReadM = rd[0];  assign if2.MemWriteM = wr[0];
  assign if2.AddrM = addr[0];   assign if2.WriteDataM = wdata[0];
  assign if0.MemReadM = rd[1];  assign if0.MemWriteM = wr[1];
  assign if0.AddrM = addr[1];   assign if0.WriteDataM = wdata[1];
  assign st[0] = if2.MemStallM; assign mi[0] = if2.MisalignM;
  assign bz[0] = if2.BusyM;     assign rdv[0] = if2.ReadDataM;
  assign st[1] = if0.MemStallM; assign mi[1] = if0.MisalignM;
  assign bz[1] = if0.BusyM;     assign rdv[1] = if0.ReadDataM;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock with the given request applied to DUT d; outputs checked mid-cycle.
  task automatic vec(input int d, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic es, input logic em, input logic eb,
                     input logic [31:0] erd, input string nm);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
    @(negedge clk);
    chk({nm, " stall"}, 32'(st[d]), 32'(es));
    chk({nm, " misalign"}, 32'(mi[d]), 32'(em));
    chk({nm, " busy"}, 32'(bz[d]), 32'(eb));
    chk({nm, " rdata"}, rdv[d], erd);
    @(posedge clk); #1;
  endtask

  // Full aligned access on the two-wait-state DUT.
  task automatic acc2(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] erd, input string nm);
    vec(0, r, w, a, wd, 1'b1, 1'b0, 1'b0, 32'h0, {nm, " c1"});
    vec(0, r, w, a, wd, 1'b1, 1'b0, 1'b1, 32'h0, {nm, " c2"});
    vec(0, r, w, a, wd, 1'b0, 1'b0, 1'b1, erd,   {nm, " c3"});
  endtask

  typedef struct {
    logic        r, w;
    logic [31:0] a, wd;
    logic        es, em, eb;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic es, input logic em,
                              input logic eb, input logic [31:0] erd);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.wd = wd; v.es = es; v.em = em; v.eb = eb; v.erd = erd;
    return v;
  endfunction

  // Reference model: count cycles into the current access; the access completes on
  // cycle wc+1, stalls on cycles 1..wc, and a dropped request abandons it.
  logic [31:0] mm [2][16];
  int          tcnt [2];

  task automatic model_cycle(input int d, input int wc);
    logic        req, al, es, em, eb, comp;
    logic [31:0] erd;
    int          idx, tn;
    req = rd[d] | wr[d];
    al  = (addr[d][1:0] == 2'b00);
    idx = int'(addr[d][5:2]);
    es = 1'b0; em = 1'b0; erd = 32'h0; comp = 1'b0; tn = 0;
    eb = (tcnt[d] > 0);
    if (req && !al) em = 1'b1;
    else if (req) begin
      tn   = tcnt[d] + 1;
      es   = (tn <= wc);
      comp = (tn == wc + 1);
      if (comp && rd[d]) erd = mm[d][idx];
    end
    @(negedge clk);
    chk("rand stall", 32'(st[d]), 32'(es));
    chk("rand misalign", 32'(mi[d]), 32'(em));
    chk("rand busy", 32'(bz[d]), 32'(eb));
    chk("rand rdata", rdv[d], erd);
    @(posedge clk); #1;
    if (comp && wr[d]) mm[d][idx] = wdata[d];
    tcnt[d] = comp ? 0 : tn;
  endtask

  vec_t tbl [$];

  initial begin
    int wc, word, off, kind, nhold, nidle;
    bit mis, flush;

    reset = 1'b1; rd = '0; wr = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    @(posedge clk); #1;
    // reset state, even with a request presented
    vec(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "reset dut2");
    vec(1, 1'b1, 1'b0, 32'h6,  32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "reset dut0");
    rd = '0;
    reset = 1'b0;

    tbl.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 1, 0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10, 32'h0,        1, 0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10, 32'h0,        0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 32'h6,  32'h0,        0, 1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h12, 32'hFFFFFFFF, 0, 1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10, 32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10, 32'h0,        1, 0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10, 32'h0,        0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 32'h400, 32'hA5A5A5A5, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h400, 32'hA5A5A5A5, 1, 0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 32'h400, 32'hA5A5A5A5, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,  32'h0,        1, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,  32'h0,        1, 0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,  32'h0,        0, 0, 1, 32'hA5A5A5A5));
    tbl.push_back(mk(0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0));
    for (int i = 0; i < tbl.size(); i++)
      vec(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].es, tbl[i].em, tbl[i].eb,
          tbl[i].erd, $sformatf("tbl%0d", i));

    // zero-wait memory: store then load next cycle, plus misaligned access
    vec(1, 0, 1, 32'h4, 32'h12345678, 0, 0, 0, 32'h0, "w0 store");
    vec(1, 1, 0, 32'h4, 32'h0,        0, 0, 0, 32'h12345678, "w0 load");
    vec(1, 0, 1, 32'h5, 32'hFFFFFFFF, 0, 1, 0, 32'h0, "w0 mis store");
    vec(1, 1, 0, 32'h4, 32'h0,        0, 0, 0, 32'h12345678, "w0 reload");
    vec(1, 0, 0, 32'h0, 32'h0,        0, 0, 0, 32'h0, "w0 idle");

    // reset during WAIT abandons the store
    acc2(0, 1, 32'h20, 32'h11111111, 32'h0, "pre 20");
    vec(0, 0, 1, 32'h20, 32'h22222222, 1, 0, 0, 32'h0, "rst c1");
    reset = 1'b1;
    vec(0, 0, 1, 32'h20, 32'h22222222, 0, 0, 0, 32'h0, "rst in wait");
    reset = 1'b0;
    vec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, "rst idle");
    acc2(1, 0, 32'h20, 32'h0, 32'h11111111, "after rst load");

    // flush in WAIT: stall drops at once, no write
    vec(0, 0, 1, 32'h20, 32'h33333333, 1, 0, 0, 32'h0, "flush c1");
    vec(0, 0, 0, 32'h20, 32'h33333333, 0, 0, 1, 32'h0, "flush drop");
    vec(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0, "flush idle");
    acc2(1, 0, 32'h20, 32'h0, 32'h11111111, "after flush load");

    // simultaneous read+write: old word returned, new word stored
    acc2(0, 1, 32'h8, 32'h1, 32'h0, "rw pre");
    acc2(1, 1, 32'h8, 32'h2, 32'h1, "rw");
    vec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, "rw idle");
    acc2(1, 0, 32'h8, 32'h0, 32'h2, "rw check");
    vec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, "dir end");

    // randomized traffic against the model
    for (int d = 0; d < 2; d++) begin
      wc = (d == 0) ? 2 : 0;
      tcnt[d] = 0;
      for (int w = 0; w < 16; w++) begin
        rd[d] = 1'b0; wr[d] = 1'b1; addr[d] = 32'(w) << 2; wdata[d] = $urandom;
        repeat (wc + 1) model_cycle(d, wc);
      end
      rd[d] = 1'b0; wr[d] = 1'b0;
      model_cycle(d, wc);
      for (int n = 0; n < 150; n++) begin
        word  = int'($urandom_range(0, 15));
        mis   = ($urandom_range(0, 9) == 0);
        off   = mis ? int'($urandom_range(1, 3)) : 0;
        kind  = int'($urandom_range(0, 2));
        flush = (wc > 0) && !mis && ($urandom_range(0, 7) == 0);
        rd[d] = (kind != 1); wr[d] = (kind != 0);
        addr[d]  = ($urandom & 32'hFFFF_FC00) | (32'(word) << 2) | 32'(off);
        wdata[d] = $urandom;
        nhold = mis ? 1 : (flush ? int'($urandom_range(1, wc)) : wc + 1);
        repeat (nhold) model_cycle(d, wc);
        nidle = int'($urandom_range(0, 2)) + (flush ? 1 : 0);
        rd[d] = 1'b0; wr[d] = 1'b0;
        repeat (nidle) model_cycle(d, wc);
      end
      rd[d] = 1'b0; wr[d] = 1'b0;
      model_cycle(d, wc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
